ft60x_axi_cmd_master: RTL and testbench
=======================================

Name: ft60x_axi_cmd_master

Overview:
- Command-parsing AXI4 bus master between the FT60x 32-bit stream interface (host side) and the AXI retime stage (bus side).
- Decodes host command words into single AXI4 INCR bursts: AW+W+B for writes, AR+R for reads.
- Returns read data, and a write status word, to the host on an outbound 32-bit stream.
- One command is outstanding at a time; there is no pipelining across commands.

Parameters:
- AXI_ID, 4'd0, constant ID driven on awid/arid; bid/rid are ignored.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- inport_valid_i  in  1  host stream word valid
- inport_data_i  in  32  host stream word
- inport_accept_o  out  1  host word consumed this cycle
- outport_valid_o  out  1  response word valid
- outport_data_o  out  32  response word
- outport_accept_i  in  1  response word taken
- axi_awvalid_o/awaddr_o[32]/awid_o[4]/awlen_o[8]/awburst_o[2], axi_awready_i  AXI write address channel
- axi_wvalid_o/wdata_o[32]/wstrb_o[4]/wlast_o, axi_wready_i  AXI write data channel
- axi_bvalid_i/bresp_i[2]/bid_i[4], axi_bready_o  AXI write response channel
- axi_arvalid_o/araddr_o[32]/arid_o[4]/arlen_o[8]/arburst_o[2], axi_arready_i  AXI read address channel
- axi_rvalid_i/rdata_i[32]/rresp_i[2]/rid_i[4]/rlast_i, axi_rready_o  AXI read data channel

Behaviour:
- Reset: clk_i, rst_i asynchronous active-high. All valid/ready/accept outputs 0, FSM in IDLE, len/addr/count registers 0.
- Command format:
  - Word0: [31:24] opcode (8'h10 = write, 8'h11 = read), [7:0] LEN (beats-1), other bits ignored.
  - Word1: byte address.
  - Write only: LEN+1 data words follow.
- Constant outputs: awburst/arburst = 2'b01 (INCR), wstrb = 4'hF, awlen/arlen = LEN.
- States: IDLE, ADDR, WR_AW, WR_DATA, WR_RESP, RD_AR, RD_DATA, STATUS.
- IDLE:
  - inport_accept_o = 1.
  - On valid with a legal opcode: latch opcode and LEN, go to ADDR.
  - Illegal opcode: word is consumed and dropped; stay in IDLE.
- ADDR:
  - accept = 1.
  - On valid: latch address, go to WR_AW (write) or RD_AR (read).
- WR_AW:
  - awvalid = 1, held stable until awready; then go to WR_DATA.
  - W beats are not issued before the AW handshake.
- WR_DATA:
  - wvalid = inport_valid_i, wdata = inport_data_i, inport_accept_o = axi_wready_i (combinational pass-through).
  - An 8-bit beat counter starts at 0 and increments per W handshake.
  - wlast = (count == LEN).
  - On the handshake with wlast: go to WR_RESP.
- WR_RESP:
  - bready = 1.
  - On bvalid: capture bresp, go to STATUS.
- STATUS:
  - outport_valid_o = 1, data = {8'hB0, 22'd0, bresp}, held until accept; then go to IDLE.
- RD_AR:
  - arvalid = 1 until arready; then go to RD_DATA.
- RD_DATA:
  - outport_valid_o = axi_rvalid_i, outport_data_o = rdata, axi_rready_o = outport_accept_i.
  - On the handshake with rlast_i: go to IDLE, or to STATUS when the optional feature is enabled.
  - The read beat count is not checked; rlast_i is authoritative.
- inport_accept_o = 0 in every state except IDLE, ADDR and WR_DATA.
- Boundaries:
  - LEN = 0 gives a single beat with wlast asserted on the first beat.
  - LEN = 255 gives 256 beats; the counter must not wrap before wlast.
  - Backpressure (wready = 0 or outport_accept_i = 0) stalls with no data loss and no duplicated beat.
  - AXI address is not checked against 4KB boundaries; the host is responsible.
  - Reset mid-burst aborts to IDLE; any partial AXI transaction is abandoned.
- Command latency: the AW/AR valid is registered and asserted the cycle after the address word handshake.

Optional Feature:
- Macro: FT60X_AXI_RD_STATUS_EN.
- Defined: after the last read beat the FSM enters STATUS and emits {8'hB1, 22'd0, worst rresp}. Worst rresp is the OR of all rresp beats in the burst.
- Undefined: the read response carries data words only, and no rresp logic is synthesised.

Decomposition:
- Shared package ft60x_axi_pkg holds:
  - opcode constants CMD_WRITE = 8'h10, CMD_READ = 8'h11;
  - status tags 8'hB0 and 8'hB1;
  - burst encoding INCR;
  - FSM state enum.
- No sub-module: single FSM plus datapath registers.

Test Plan:
- Write: host sends 0x10000003, 0x00001000, D0..D3 -> AW addr 0x1000 len 3; 4 W beats with wlast on D3; bresp 0 -> status word 0xB0000000.
- Read: host sends 0x11000001, 0x00002000 -> AR addr 0x2000 len 1; slave returns 0xAAAA5555 and 0x12345678 (rlast) -> two outbound words in order; with the macro, a third word 0xB1000000.
- Backpressure: wready toggles 1/0 every cycle and outport_accept_i is low for 5 cycles mid-read -> no lost or duplicated beats; valids and data held stable while stalled.
- Illegal opcode: 0x55000000 then a valid write command -> the first word is dropped and the write completes normally.
- LEN = 255 write -> 256 W beats, wlast only on beat 256; bresp 2'b10 -> status 0xB0000002.
- Reset asserted during WR_DATA -> all valids 0 immediately; the next command executes correctly.

Source files
------------

// File: rtl/ft60x_axi_pkg.sv
// Shared constants, state encoding and status-word helper for the FT60x AXI command master.
package ft60x_axi_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned RESP_W  = 2;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned OPC_W   = 8;
    localparam int unsigned STRB_W  = DATA_W / 8;

    localparam logic [OPC_W-1:0]   CMD_WRITE   = 8'h10;
    localparam logic [OPC_W-1:0]   CMD_READ    = 8'h11;
    localparam logic [OPC_W-1:0]   STAT_WR_TAG = 8'hB0;
    localparam logic [OPC_W-1:0]   STAT_RD_TAG = 8'hB1;
    localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WR_AW,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_AR,
        ST_RD_DATA,
        ST_STATUS
    } state_t;

    // Status word returned to the host: tag in the top byte, response code in the bottom bits.
    function automatic logic [DATA_W-1:0] status_word(input logic [OPC_W-1:0] tag,
                                                      input logic [RESP_W-1:0] resp);
        return {tag, 22'd0, resp};
    endfunction

endpackage

// File: rtl/ft60x_axi_cmd_master.sv
// Host command stream to single-burst AXI4 master; read status word enabled by FT60X_AXI_RD_STATUS_EN.
module ft60x_axi_cmd_master
    import ft60x_axi_pkg::*;
#(
    parameter logic [ID_W-1:0] AXI_ID = 4'd0
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                inport_valid_i,
    input  logic [DATA_W-1:0]   inport_data_i,
    output logic                inport_accept_o,

    output logic                outport_valid_o,
    output logic [DATA_W-1:0]   outport_data_o,
    input  logic                outport_accept_i,

    output logic                axi_awvalid_o,
    output logic [DATA_W-1:0]   axi_awaddr_o,
    output logic [ID_W-1:0]     axi_awid_o,
    output logic [LEN_W-1:0]    axi_awlen_o,
    output logic [BURST_W-1:0]  axi_awburst_o,
    input  logic                axi_awready_i,

    output logic                axi_wvalid_o,
    output logic [DATA_W-1:0]   axi_wdata_o,
    output logic [STRB_W-1:0]   axi_wstrb_o,
    output logic                axi_wlast_o,
    input  logic                axi_wready_i,

    input  logic                axi_bvalid_i,
    input  logic [RESP_W-1:0]   axi_bresp_i,
    input  logic [ID_W-1:0]     axi_bid_i,
    output logic                axi_bready_o,

    output logic                axi_arvalid_o,
    output logic [DATA_W-1:0]   axi_araddr_o,
    output logic [ID_W-1:0]     axi_arid_o,
    output logic [LEN_W-1:0]    axi_arlen_o,
    output logic [BURST_W-1:0]  axi_arburst_o,
    input  logic                axi_arready_i,

    input  logic                axi_rvalid_i,
    input  logic [DATA_W-1:0]   axi_rdata_i,
    input  logic [RESP_W-1:0]   axi_rresp_i,
    input  logic [ID_W-1:0]     axi_rid_i,
    input  logic                axi_rlast_i,
    output logic                axi_rready_o
);

    state_t              state_q;
    logic [OPC_W-1:0]    opcode_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    count_q;
    logic [DATA_W-1:0]   addr_q;
    logic                cmd_accept_q;
    logic                awvalid_q;
    logic                arvalid_q;
    logic                bready_q;
    logic                stat_valid_q;
    logic [DATA_W-1:0]   stat_data_q;
`ifdef FT60X_AXI_RD_STATUS_EN
    logic [RESP_W-1:0]   rresp_acc_q;
`endif

    logic                in_hs;
    logic                w_hs;
    logic                r_hs;
    logic                legal_opc;
    logic                unused_ok;

    assign in_hs     = inport_valid_i & inport_accept_o;
    assign w_hs      = axi_wvalid_o & axi_wready_i;
    assign r_hs      = axi_rvalid_i & axi_rready_o;
    assign legal_opc = (inport_data_i[31:24] == CMD_WRITE) || (inport_data_i[31:24] == CMD_READ);

    // Command FSM with registered handshake outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            opcode_q     <= '0;
            len_q        <= '0;
            count_q      <= '0;
            addr_q       <= '0;
            cmd_accept_q <= 1'b0;
            awvalid_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_data_q  <= '0;
`ifdef FT60X_AXI_RD_STATUS_EN
            rresp_acc_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cmd_accept_q <= 1'b1;
                    if (in_hs && legal_opc) begin
                        opcode_q <= inport_data_i[31:24];
                        len_q    <= inport_data_i[LEN_W-1:0];
                        state_q  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (in_hs) begin
                        addr_q       <= inport_data_i;
                        cmd_accept_q <= 1'b0;
                        if (opcode_q == CMD_WRITE) begin
                            awvalid_q <= 1'b1;
                            state_q   <= ST_WR_AW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_AR;
                        end
                    end
                end
                ST_WR_AW: begin
                    if (axi_awready_i) begin
                        awvalid_q <= 1'b0;
                        count_q   <= '0;
                        state_q   <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (w_hs) begin
                        if (axi_wlast_o) begin
                            bready_q <= 1'b1;
                            state_q  <= ST_WR_RESP;
                        end else begin
                            count_q <= count_q + LEN_W'(1);
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (axi_bvalid_i) begin
                        bready_q     <= 1'b0;
                        stat_valid_q <= 1'b1;
                        stat_data_q  <= status_word(STAT_WR_TAG, axi_bresp_i);
                        state_q      <= ST_STATUS;
                    end
                end
                ST_RD_AR: begin
                    if (axi_arready_i) begin
                        arvalid_q   <= 1'b0;
`ifdef FT60X_AXI_RD_STATUS_EN
                        rresp_acc_q <= '0;
`endif
                        state_q     <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (r_hs) begin
`ifdef FT60X_AXI_RD_STATUS_EN
                        rresp_acc_q <= rresp_acc_q | axi_rresp_i;
                        if (axi_rlast_i) begin
                            stat_valid_q <= 1'b1;
                            stat_data_q  <= status_word(STAT_RD_TAG, rresp_acc_q | axi_rresp_i);
                            state_q      <= ST_STATUS;
                        end
`else
                        if (axi_rlast_i) begin
                            cmd_accept_q <= 1'b1;
                            state_q      <= ST_IDLE;
                        end
`endif
                    end
                end
                ST_STATUS: begin
                    if (outport_accept_i) begin
                        stat_valid_q <= 1'b0;
                        cmd_accept_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Data phases pass straight through between the host stream and the AXI data channels.
    assign inport_accept_o = ((state_q == ST_IDLE) || (state_q == ST_ADDR)) ? cmd_accept_q :
                             (state_q == ST_WR_DATA) ? axi_wready_i : 1'b0;

    assign outport_valid_o = (state_q == ST_RD_DATA) ? axi_rvalid_i : stat_valid_q;
    assign outport_data_o  = (state_q == ST_RD_DATA) ? axi_rdata_i  : stat_data_q;

    assign axi_awvalid_o = awvalid_q;
    assign axi_awaddr_o  = addr_q;
    assign axi_awid_o    = AXI_ID;
    assign axi_awlen_o   = len_q;
    assign axi_awburst_o = BURST_INCR;

    assign axi_wvalid_o = (state_q == ST_WR_DATA) & inport_valid_i;
    assign axi_wdata_o  = inport_data_i;
    assign axi_wstrb_o  = {STRB_W{1'b1}};
    assign axi_wlast_o  = (state_q == ST_WR_DATA) & (count_q == len_q);

    assign axi_bready_o = bready_q;

    assign axi_arvalid_o = arvalid_q;
    assign axi_araddr_o  = addr_q;
    assign axi_arid_o    = AXI_ID;
    assign axi_arlen_o   = len_q;
    assign axi_arburst_o = BURST_INCR;

    assign axi_rready_o = (state_q == ST_RD_DATA) & outport_accept_i;

    // Response IDs are never checked; rresp only matters when read status is built.
`ifdef FT60X_AXI_RD_STATUS_EN
    assign unused_ok = ^{axi_bid_i, axi_rid_i};
`else
    assign unused_ok = ^{axi_bid_i, axi_rid_i, axi_rresp_i};
`endif

endmodule

// File: tb/tb_ft60x_axi_cmd_master.sv
// Self-checking bench: random AXI slave and host sink against a transaction-level expectation model.
module tb_ft60x_axi_cmd_master;
    import ft60x_axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        inport_valid_i;
    logic [31:0] inport_data_i;
    logic        inport_accept_o;
    logic        outport_valid_o;
    logic [31:0] outport_data_o;
    logic        outport_accept_i;
    logic        axi_awvalid_o;
    logic [31:0] axi_awaddr_o;
    logic [3:0]  axi_awid_o;
    logic [7:0]  axi_awlen_o;
    logic [1:0]  axi_awburst_o;
    logic        axi_awready_i;
    logic        axi_wvalid_o;
    logic [31:0] axi_wdata_o;
    logic [3:0]  axi_wstrb_o;
    logic        axi_wlast_o;
    logic        axi_wready_i;
    logic        axi_bvalid_i;
    logic [1:0]  axi_bresp_i;
    logic [3:0]  axi_bid_i;
    logic        axi_bready_o;
    logic        axi_arvalid_o;
    logic [31:0] axi_araddr_o;
    logic [3:0]  axi_arid_o;
    logic [7:0]  axi_arlen_o;
    logic [1:0]  axi_arburst_o;
    logic        axi_arready_i;
    logic        axi_rvalid_i;
    logic [31:0] axi_rdata_i;
    logic [1:0]  axi_rresp_i;
    logic [3:0]  axi_rid_i;
    logic        axi_rlast_i;
    logic        axi_rready_o;

    ft60x_axi_cmd_master dut (
        .clk_i(clk), .rst_i(rst_i),
        .inport_valid_i(inport_valid_i), .inport_data_i(inport_data_i), .inport_accept_o(inport_accept_o),
        .outport_valid_o(outport_valid_o), .outport_data_o(outport_data_o), .outport_accept_i(outport_accept_i),
        .axi_awvalid_o(axi_awvalid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awid_o(axi_awid_o),
        .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o), .axi_awready_i(axi_awready_i),
        .axi_wvalid_o(axi_wvalid_o), .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o),
        .axi_wlast_o(axi_wlast_o), .axi_wready_i(axi_wready_i),
        .axi_bvalid_i(axi_bvalid_i), .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i), .axi_bready_o(axi_bready_o),
        .axi_arvalid_o(axi_arvalid_o), .axi_araddr_o(axi_araddr_o), .axi_arid_o(axi_arid_o),
        .axi_arlen_o(axi_arlen_o), .axi_arburst_o(axi_arburst_o), .axi_arready_i(axi_arready_i),
        .axi_rvalid_i(axi_rvalid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
        .axi_rid_i(axi_rid_i), .axi_rlast_i(axi_rlast_i), .axi_rready_o(axi_rready_o)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] addr; logic [7:0] len; } addr_rec_t;
    typedef struct packed { logic [31:0] data; logic [1:0] resp; } rbeat_t;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    addr_rec_t   aw_q[$];
    addr_rec_t   ar_q[$];
    logic [31:0] w_data_q[$];
    bit          w_last_q[$];
    logic [31:0] out_q[$];
    rbeat_t      r_q[$];
    logic [31:0] rd_cfg_data[$];
    logic [1:0]  rd_cfg_resp[$];

    bit          b_pending = 0;
    logic [1:0]  b_resp_cfg = 2'b00;
    bit          wr_toggle = 0;
    bit          out_stall = 0;
    bit          out_rand = 0;
    bit          aw_seen = 0;
    bit          prev_aw_stall = 0;
    logic [31:0] prev_awaddr = '0;
    bit          prev_out_stall = 0;
    logic [31:0] prev_out_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // AXI slave: random ready/valid, records every handshake seen by the bus.
    initial begin
        axi_awready_i = 0; axi_wready_i = 0; axi_bvalid_i = 0; axi_bresp_i = 0; axi_bid_i = 0;
        axi_arready_i = 0; axi_rvalid_i = 0; axi_rdata_i = 0; axi_rresp_i = 0; axi_rid_i = 0; axi_rlast_i = 0;
        forever begin
            @(negedge clk);
            axi_awready_i = 1'($urandom_range(0, 1));
            axi_arready_i = 1'($urandom_range(0, 1));
            axi_wready_i  = wr_toggle ? ~axi_wready_i : ($urandom_range(0, 3) != 0);
            axi_bvalid_i  = b_pending;
            axi_bresp_i   = b_resp_cfg;
            axi_bid_i     = 4'($urandom);
            axi_rid_i     = 4'($urandom);
            if (r_q.size() > 0) begin
                if (!axi_rvalid_i) axi_rvalid_i = 1'($urandom_range(0, 1));
                axi_rdata_i = r_q[0].data;
                axi_rresp_i = r_q[0].resp;
                axi_rlast_i = (r_q.size() == 1);
            end else begin
                axi_rvalid_i = 0;
                axi_rlast_i  = 0;
            end
            #4;
            if (prev_aw_stall) begin
                check("aw_hold_valid", 32'(axi_awvalid_o), 32'd1);
                check("aw_hold_addr", axi_awaddr_o, prev_awaddr);
            end
            prev_aw_stall = axi_awvalid_o && !axi_awready_i;
            prev_awaddr   = axi_awaddr_o;
            if (axi_awvalid_o && axi_awready_i) begin
                aw_q.push_back('{axi_awaddr_o, axi_awlen_o});
                check("awburst", 32'(axi_awburst_o), 32'd1);
                check("awid", 32'(axi_awid_o), 32'd0);
                aw_seen = 1;
            end
            if (axi_wvalid_o && axi_wready_i) begin
                check("w_after_aw", 32'(aw_seen), 32'd1);
                w_data_q.push_back(axi_wdata_o);
                w_last_q.push_back(axi_wlast_o);
                if (axi_wlast_o) begin
                    check("wstrb", 32'(axi_wstrb_o), 32'hF);
                    b_pending = 1;
                    aw_seen   = 0;
                end
            end
            if (axi_bvalid_i && axi_bready_o) b_pending = 0;
            if (axi_arvalid_o && axi_arready_i) begin
                ar_q.push_back('{axi_araddr_o, axi_arlen_o});
                check("arburst", 32'(axi_arburst_o), 32'd1);
                check("arid", 32'(axi_arid_o), 32'd0);
                for (int i = 0; i <= int'(axi_arlen_o) && i < rd_cfg_data.size(); i++)
                    r_q.push_back('{rd_cfg_data[i], rd_cfg_resp[i]});
            end
            if (axi_rvalid_i && axi_rready_o) void'(r_q.pop_front());
        end
    end

    // Host response sink: optional backpressure, checks stalled words stay put.
    initial begin
        outport_accept_i = 0;
        forever begin
            @(negedge clk);
            outport_accept_i = out_stall ? 1'b0 : (out_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            #4;
            if (prev_out_stall && !rst_i) begin
                check("out_hold_valid", 32'(outport_valid_o), 32'd1);
                check("out_hold_data", outport_data_o, prev_out_data);
            end
            if (outport_valid_o && outport_accept_i) out_q.push_back(outport_data_o);
            prev_out_stall = outport_valid_o && !outport_accept_i && !rst_i;
            prev_out_data  = outport_data_o;
        end
    end

    task automatic clear_recs();
        aw_q.delete(); ar_q.delete(); w_data_q.delete(); w_last_q.delete(); out_q.delete();
    endtask

    // Present one host word (call at a negedge); returns at the negedge after it is consumed.
    task automatic host_send(input logic [31:0] w);
        bit accepted = 0;
        inport_valid_i = 1'b1;
        inport_data_i  = w;
        for (int t = 0; t < 4000 && !accepted; t++) begin
            #4;
            accepted = inport_accept_o;
            @(negedge clk);
        end
        inport_valid_i = 1'b0;
        if (!accepted) check("host_accept_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic wait_out(input int n);
        for (int t = 0; t < 6000 && out_q.size() < n; t++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic run_write(input logic [31:0] addr, input int len, input logic [1:0] resp);
        logic [31:0] d[$];
        clear_recs();
        b_resp_cfg = resp;
        for (int i = 0; i <= len; i++) d.push_back($urandom);
        host_send({CMD_WRITE, 16'($urandom), 8'(len)});
        host_send(addr);
        check("aw_latency", 32'(axi_awvalid_o), 32'd1);
        for (int i = 0; i <= len; i++) host_send(d[i]);
        wait_out(1);
        check("wr_aw_count", 32'(aw_q.size()), 32'd1);
        if (aw_q.size() > 0) begin
            check("wr_awaddr", aw_q[0].addr, addr);
            check("wr_awlen", 32'(aw_q[0].len), 32'(len));
        end
        check("wr_beats", 32'(w_data_q.size()), 32'(len + 1));
        for (int i = 0; i < w_data_q.size() && i <= len; i++) begin
            check("wr_wdata", w_data_q[i], d[i]);
            check("wr_wlast", 32'(w_last_q[i]), 32'(i == len));
        end
        check("wr_status_count", 32'(out_q.size()), 32'd1);
        if (out_q.size() > 0) check("wr_status", out_q[0], {8'hB0, 22'd0, resp});
    endtask

    task automatic fill_rd(input int len);
        rd_cfg_data.delete(); rd_cfg_resp.delete();
        for (int i = 0; i <= len; i++) begin
            rd_cfg_data.push_back($urandom);
            rd_cfg_resp.push_back(2'($urandom));
        end
    endtask

    task automatic run_read(input logic [31:0] addr, input int len, input bit stall);
        int n_exp;
        logic [1:0] worst = 2'b00;
        clear_recs();
        for (int i = 0; i <= len; i++) worst = worst | rd_cfg_resp[i];
`ifdef FT60X_AXI_RD_STATUS_EN
        n_exp = len + 2;
`else
        n_exp = len + 1;
`endif
        host_send({CMD_READ, 16'($urandom), 8'(len)});
        host_send(addr);
        check("ar_latency", 32'(axi_arvalid_o), 32'd1);
        if (stall) begin
            for (int t = 0; t < 2000 && out_q.size() < 1; t++) @(negedge clk);
            out_stall = 1;
            repeat (5) @(negedge clk);
            out_stall = 0;
        end
        wait_out(n_exp);
        check("rd_ar_count", 32'(ar_q.size()), 32'd1);
        if (ar_q.size() > 0) begin
            check("rd_araddr", ar_q[0].addr, addr);
            check("rd_arlen", 32'(ar_q[0].len), 32'(len));
        end
        check("rd_out_count", 32'(out_q.size()), 32'(n_exp));
        for (int i = 0; i < out_q.size() && i <= len; i++) check("rd_data", out_q[i], rd_cfg_data[i]);
`ifdef FT60X_AXI_RD_STATUS_EN
        if (out_q.size() > len + 1) check("rd_status", out_q[len + 1], {8'hB1, 22'd0, worst});
`endif
    endtask

    initial begin
        rst_i = 1'b1;
        inport_valid_i = 1'b0;
        inport_data_i  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_awvalid", 32'(axi_awvalid_o), 32'd0);
        check("rst_arvalid", 32'(axi_arvalid_o), 32'd0);
        check("rst_wvalid", 32'(axi_wvalid_o), 32'd0);
        check("rst_bready", 32'(axi_bready_o), 32'd0);
        check("rst_rready", 32'(axi_rready_o), 32'd0);
        check("rst_outvalid", 32'(outport_valid_o), 32'd0);
        check("rst_accept", 32'(inport_accept_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        run_write(32'h0000_1000, 3, 2'b00);

        fill_rd(1);
        rd_cfg_data[0] = 32'hAAAA5555; rd_cfg_data[1] = 32'h12345678;
        rd_cfg_resp[0] = 2'b00;        rd_cfg_resp[1] = 2'b00;
        run_read(32'h0000_2000, 1, 1'b0);

        wr_toggle = 1;
        run_write(32'h0000_3000, 5, 2'b01);
        wr_toggle = 0;
        fill_rd(7);
        run_read(32'h0000_4000, 7, 1'b1);

        clear_recs();
        host_send(32'h5500_0000);
        run_write(32'h0000_5000, 2, 2'b00);

        run_write(32'h0001_0000, 255, 2'b10);

        out_rand = 1;
        for (int k = 0; k < 6; k++) begin
            int len = $urandom_range(0, 15);
            logic [31:0] a = {$urandom} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 0) run_write(a, len, 2'($urandom));
            else begin
                fill_rd(len);
                run_read(a, len, 1'b0);
            end
        end
        out_rand = 0;

        // Abort a write burst midway with reset, then run a clean command.
        clear_recs();
        host_send({CMD_WRITE, 16'd0, 8'd7});
        host_send(32'h0000_6000);
        for (int i = 0; i < 3; i++) host_send($urandom);
        inport_valid_i = 1'b1;
        inport_data_i  = $urandom;
        rst_i = 1'b1;
        #1;
        check("midrst_wvalid", 32'(axi_wvalid_o), 32'd0);
        check("midrst_wlast", 32'(axi_wlast_o), 32'd0);
        check("midrst_accept", 32'(inport_accept_o), 32'd0);
        check("midrst_awvalid", 32'(axi_awvalid_o), 32'd0);
        check("midrst_outvalid", 32'(outport_valid_o), 32'd0);
        @(negedge clk);
        inport_valid_i = 1'b0;
        rst_i = 1'b0;
        aw_seen = 0; b_pending = 0; r_q.delete();
        prev_aw_stall = 0; prev_out_stall = 0;
        @(negedge clk);
        run_write(32'h0000_7000, 4, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
